dot_accum: RTL

Downstream accumulation stage for the 8-lane dot-product pipeline. It consumes the stream of partial dot products (`ivalid`/`idata`, matching the dot-product output width) and sums a runtime-selected number of consecutive partials into one long dot product. It saturates the sum to the output width and buffers completed results in a small FIFO with a ready/valid output. The upstream stage cannot stall, so overruns are flagged rather than back-pressured.

---
 rtl/dot_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/dot_accum.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// Shared widths and helpers for the dot-product pipeline and its
// accumulation stage.
package dot_pkg;

  localparam int DOT_IWIDTH = 32;
  localparam int DOT_OWIDTH = 32;
  localparam int DOT_MAXLEN = 64;
  localparam int DOT_DEPTH  = 4;
  localparam int SAT_W      = 64;

  function automatic int len_w(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

  function automatic int acc_w(input int iw, input int maxlen);
    return iw + $clog2(maxlen);
  endfunction

  // Clamp a sign-extended accumulator value into a signed ow-bit range.
  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v,
                                                     input int ow);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage; head entry is always
// visible on dout. Push while full is ignored unless a pop happens too.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  // Pointer update; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= {(PW+1){1'b0}};
      rd_ptr <= {(PW+1){1'b0}};
    end else if (flush) begin
      wr_ptr <= {(PW+1){1'b0}};
      rd_ptr <= {(PW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (!flush && do_push) begin
      mem[wr_ptr[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/dot_accum.sv
// Sums a runtime-selected number of consecutive partial dot products,
// saturates the result and queues it for a ready/valid consumer.
module dot_accum
  import dot_pkg::*;
#(
  parameter int IWIDTH = DOT_IWIDTH,
  parameter int OWIDTH = DOT_OWIDTH,
  parameter int MAXLEN = DOT_MAXLEN,
  parameter int DEPTH  = DOT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [len_w(MAXLEN)-1:0]   len,
  input  logic                       flush,
  input  logic                       ivalid,
  input  logic signed [IWIDTH-1:0]   idata,
  output logic signed [OWIDTH-1:0]   odata,
  output logic                       ovalid,
  input  logic                       oready,
  output logic                       busy,
  output logic                       overflow
);

  localparam int LW   = len_w(MAXLEN);
  localparam int ACCW = acc_w(IWIDTH, MAXLEN);
  localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LEN_ONE  = LW'(1'b1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAXLEN);

  logic [LW-1:0]            cnt;
  logic [LW-1:0]            glen;
  logic [LW-1:0]            cnt_next;
  logic [LW-1:0]            glen_next;
  logic [LW-1:0]            first_len;
  logic [LW-1:0]            eff_len;
  logic signed [ACCW-1:0]   acc;
  logic signed [ACCW-1:0]   acc_next;
  logic signed [ACCW-1:0]   part;
  logic signed [ACCW-1:0]   sum;
  logic [OWIDTH-1:0]        sat_sum;
  logic [OWIDTH-1:0]        head;
  logic                     done;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     drop;

  assign part    = ACCW'(idata);
  assign sat_sum = OWIDTH'(sat_to(SAT_W'(sum), OWIDTH));

  // Group length for a group opened this cycle: 0 means 1, oversize clamps.
  always_comb begin
    if (len == LEN_ZERO) begin
      first_len = LEN_ONE;
    end else if (len > LEN_MAX) begin
      first_len = LEN_MAX;
    end else begin
      first_len = len;
    end
  end

  // Next accumulator/counter state and completion detection.
  always_comb begin
    cnt_next  = cnt;
    glen_next = glen;
    acc_next  = acc;
    push      = 1'b0;
    eff_len   = (cnt == LEN_ZERO) ? first_len : glen;
    sum       = (cnt == LEN_ZERO) ? part : (acc + part);
    done      = (cnt == (eff_len - LEN_ONE));
    if (flush) begin
      cnt_next = LEN_ZERO;
      acc_next = {ACCW{1'b0}};
    end else if (ivalid) begin
      acc_next  = sum;
      glen_next = eff_len;
      if (done) begin
        cnt_next = LEN_ZERO;
        push     = 1'b1;
      end else begin
        cnt_next = cnt + LEN_ONE;
      end
    end else begin
      cnt_next = cnt;
    end
  end

  assign pop  = oready && !empty;
  assign drop = push && full && !pop;

  // Group state, busy flag and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= LEN_ZERO;
      glen     <= LEN_ZERO;
      acc      <= {ACCW{1'b0}};
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      glen     <= glen_next;
      acc      <= acc_next;
      busy     <= (cnt_next != LEN_ZERO);
      overflow <= overflow | drop;
    end
  end

  sync_fifo #(
    .WIDTH(OWIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (sat_sum),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign odata  = head;
  assign ovalid = !empty;

endmodule
